uart_arbiter: RTL and testbench
===============================

UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 means requester 0 always wins a tie.
REQ-002 The block SHALL use one clock and a synchronous active-low reset: clk in 1 rising-edge clock; rstn in 1 synchronous active-low reset.
REQ-003 Requester ports, with x = 0 or 1: mx_renable in 1 (one-cycle read request pulse); mx_rsize in 2 (read size, 00 byte, 11 word); mx_rdone out 1 (read-complete pulse); mx_rdata out 32 (read data).
REQ-004 Requester ports, with x = 0 or 1: mx_wenable in 1 (one-cycle write request pulse); mx_wsize in 2 (write size); mx_wdata in 32 (write data); mx_wdone out 1 (write-complete pulse).
REQ-005 Buffer-side ports: renable out 1; rsize out 2; rdone in 1; rdata in 32; wenable out 1; wsize out 2; wdata out 32; wdone in 1. These connect one-to-one to the UART buffer request interface.

Function
REQ-006 The read channel and the write channel SHALL be independent instances of the same arbitration logic and SHALL be able to operate concurrently; REQ-007 to REQ-016 are stated for the read channel, and the write channel is identical with w substituted for r.
REQ-007 Each requester x SHALL have a pending flag, plus latched size (and latched data on the write channel), captured at the edge where mx_renable=1.
REQ-008 A request pulse from requester x while pend_x=1 SHALL be ignored, except when it arrives in the same cycle as that requester's completion (see REQ-014).
REQ-009 FSM states: IDLE and WAIT.
REQ-010 In IDLE with at least one pending flag set, the block SHALL grant one requester and drive renable=1 for exactly one cycle, with rsize equal to the granted requester's latched size, then move to WAIT.
REQ-011 Grant rule:
- Only one requester pending: that requester wins.
- Both pending, FIXED_PRIO=1: requester 0 wins.
- Both pending, FIXED_PRIO=0: the requester not served last wins; after reset, requester 0 counts as served last, so requester 1 wins first.
REQ-012 In WAIT, renable SHALL be 0 and rsize SHALL stay stable at the granted requester's size; the block remains in WAIT until rdone=1.
REQ-013 At the edge where rdone=1 in WAIT:
- mg_rdata is loaded with rdata and mg_rdone=1 for exactly one cycle, where g is the granted requester.
- pend_g is cleared, the last-served record is set to g, and the FSM returns to IDLE.
REQ-014 If requester g pulses mg_renable in the same cycle its completion is taken, the new request SHALL be latched and pend_g SHALL remain 1.
REQ-015 Latency (unloaded channel):
- Request pulse in cycle t gives renable=1 in cycle t+1.
- rdone in cycle d gives mx_rdone=1 in cycle d+1.
- Minimum spacing between two renable pulses is 3 cycles (done, IDLE, issue).
REQ-016 rdone arriving while in IDLE SHALL be ignored and SHALL produce no requester done.
REQ-017 mx_rdata SHALL hold its value until the next completion for the same requester.
REQ-018 The grant never changes while in WAIT. A request arriving for the other requester during WAIT stays pending and is served on the next IDLE.
REQ-019 The write channel SHALL drive wdata from the granted requester's latched data, stable from the renable-equivalent cycle (the wenable cycle) through completion.

Reset
REQ-020 While rstn=0 at a clock edge, the block SHALL set:
- Both FSMs to IDLE.
- All pending flags to 0.
- Last-served to requester 0.
- All outputs to 0: renable, wenable, rsize, wsize, wdata, mx_rdone, mx_rdata and mx_wdone.
REQ-021 A reset asserted during WAIT SHALL abandon the transfer without issuing any requester done. A buffer done arriving after reset is ignored per REQ-016.

Verification
REQ-022 m0_renable pulse with rsize=11, buffer returns rdone two cycles after renable with rdata=0x12345678 -> exactly one renable pulse with rsize=11; m0_rdone one cycle after rdone; m0_rdata=0x12345678; m1_rdone stays 0.
REQ-023 Both requesters pulse renable in the same cycle after reset (FIXED_PRIO=0) -> requester 1 is served first, then requester 0. Two renable pulses, each following the previous rdone by 2 cycles.
REQ-024 Same stimulus as REQ-023 with FIXED_PRIO=1 -> requester 0 is served first.
REQ-025 m0 write (wsize=00, wdata=0x41) and m1 read issued in the same cycle -> wenable and renable are both asserted in the next cycle. wdata=0x41. The dones are independent.
REQ-026 m1 pulses again while pending, and separately in its rdone cycle -> the first extra pulse produces no extra transfer; the second produces one further renable.
REQ-027 rstn=0 during WAIT, followed by rdone=1 after reset -> no mx_rdone; all outputs remain 0.

Source files
------------

// File: rtl/uart_arbiter_if.sv
// Bundle of the two requester ports and the UART buffer request port.
// The arbiter uses the slave view; the requesters and the buffer use the master view.
interface uart_arbiter_if;
    logic        m0_renable;
    logic        m1_renable;
    logic [1:0]  m0_rsize;
    logic [1:0]  m1_rsize;
    logic        m0_rdone;
    logic        m1_rdone;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic        m0_wenable;
    logic        m1_wenable;
    logic [1:0]  m0_wsize;
    logic [1:0]  m1_wsize;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m0_wdone;
    logic        m1_wdone;
    logic        renable;
    logic [1:0]  rsize;
    logic        rdone;
    logic [31:0] rdata;
    logic        wenable;
    logic [1:0]  wsize;
    logic [31:0] wdata;
    logic        wdone;

    modport slave (
        input  m0_renable, m1_renable, m0_rsize, m1_rsize,
        input  m0_wenable, m1_wenable, m0_wsize, m1_wsize, m0_wdata, m1_wdata,
        input  rdone, rdata, wdone,
        output m0_rdone, m1_rdone, m0_rdata, m1_rdata, m0_wdone, m1_wdone,
        output renable, rsize, wenable, wsize, wdata
    );

    modport master (
        output m0_renable, m1_renable, m0_rsize, m1_rsize,
        output m0_wenable, m1_wenable, m0_wsize, m1_wsize, m0_wdata, m1_wdata,
        output rdone, rdata, wdone,
        input  m0_rdone, m1_rdone, m0_rdata, m1_rdata, m0_wdone, m1_wdone,
        input  renable, rsize, wenable, wsize, wdata
    );
endinterface

// File: rtl/uart_arbiter.sv
// Two-requester arbiter in front of the UART buffer. Read and write channels each
// run their own copy of the pending/grant FSM; the top level adds the size/data paths.
module uart_arbiter_core #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_req,
    input  logic       i_done,
    output logic [1:0] o_accept,
    output logic       o_load,
    output logic       o_winner,
    output logic       o_take,
    output logic       o_issue,
    output logic       o_grant
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_pend;
    logic [1:0] w_pendEff;
    logic [1:0] w_clearMask;
    logic       r_last;
    logic       r_grant;
    logic       r_issue;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_pend  <= 2'b00;
            r_last  <= 1'b0;
            r_grant <= 1'b0;
            r_issue <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_issue <= o_load;
            r_pend  <= (r_pend & ~w_clearMask) | o_accept;
            if (o_load) r_grant <= o_winner;
            if (o_take) r_last <= r_grant;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (o_load) w_nextState = WAIT;
            WAIT: if (i_done) w_nextState = IDLE;
        endcase
    end

    // A new pulse from the requester being completed this cycle is accepted,
    // and a request arriving while idle is granted at the same edge it is latched.
    always_comb begin
        o_take      = (r_state == WAIT) && i_done;
        w_clearMask = 2'b00;
        if (o_take) w_clearMask[r_grant] = 1'b1;
        o_accept    = i_req & (~r_pend | w_clearMask);
        w_pendEff   = r_pend | o_accept;
        case (w_pendEff)
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = FIXED_PRIO ? 1'b0 : ~r_last;
            default: o_winner = 1'b0;
        endcase
        o_load      = (r_state == IDLE) && (w_pendEff != 2'b00);
    end

    assign o_issue = r_issue;
    assign o_grant = r_grant;
endmodule

module uart_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic           clk,
    input  logic           rstn,
    uart_arbiter_if.slave  bus
);
    logic [1:0]  w_rAccept;
    logic        w_rLoad;
    logic        w_rWinner;
    logic        w_rTake;
    logic        w_rIssue;
    logic        w_rGrant;
    logic [1:0]  w_wAccept;
    logic        w_wLoad;
    logic        w_wWinner;
    logic        w_wTake;
    logic        w_wIssue;
    logic        w_wGrant;

    logic [1:0]  r_rSizeLat0;
    logic [1:0]  r_rSizeLat1;
    logic [1:0]  r_rsize;
    logic        r_m0Rdone;
    logic        r_m1Rdone;
    logic [31:0] r_m0Rdata;
    logic [31:0] r_m1Rdata;
    logic [1:0]  r_wSizeLat0;
    logic [1:0]  r_wSizeLat1;
    logic [31:0] r_wDataLat0;
    logic [31:0] r_wDataLat1;
    logic [1:0]  r_wsize;
    logic [31:0] r_wdata;
    logic        r_m0Wdone;
    logic        r_m1Wdone;

    logic [1:0]  w_rSizeEff0;
    logic [1:0]  w_rSizeEff1;
    logic [1:0]  w_wSizeEff0;
    logic [1:0]  w_wSizeEff1;
    logic [31:0] w_wDataEff0;
    logic [31:0] w_wDataEff1;

    uart_arbiter_core #(.FIXED_PRIO(FIXED_PRIO)) u_readArb (
        .clk      (clk),
        .rstn     (rstn),
        .i_req    ({bus.m1_renable, bus.m0_renable}),
        .i_done   (bus.rdone),
        .o_accept (w_rAccept),
        .o_load   (w_rLoad),
        .o_winner (w_rWinner),
        .o_take   (w_rTake),
        .o_issue  (w_rIssue),
        .o_grant  (w_rGrant)
    );

    uart_arbiter_core #(.FIXED_PRIO(FIXED_PRIO)) u_writeArb (
        .clk      (clk),
        .rstn     (rstn),
        .i_req    ({bus.m1_wenable, bus.m0_wenable}),
        .i_done   (bus.wdone),
        .o_accept (w_wAccept),
        .o_load   (w_wLoad),
        .o_winner (w_wWinner),
        .o_take   (w_wTake),
        .o_issue  (w_wIssue),
        .o_grant  (w_wGrant)
    );

    // A request granted at the edge it arrives has not been latched yet, so bypass it.
    assign w_rSizeEff0 = w_rAccept[0] ? bus.m0_rsize : r_rSizeLat0;
    assign w_rSizeEff1 = w_rAccept[1] ? bus.m1_rsize : r_rSizeLat1;
    assign w_wSizeEff0 = w_wAccept[0] ? bus.m0_wsize : r_wSizeLat0;
    assign w_wSizeEff1 = w_wAccept[1] ? bus.m1_wsize : r_wSizeLat1;
    assign w_wDataEff0 = w_wAccept[0] ? bus.m0_wdata : r_wDataLat0;
    assign w_wDataEff1 = w_wAccept[1] ? bus.m1_wdata : r_wDataLat1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rSizeLat0 <= 2'b00;
            r_rSizeLat1 <= 2'b00;
            r_rsize     <= 2'b00;
            r_m0Rdone   <= 1'b0;
            r_m1Rdone   <= 1'b0;
            r_m0Rdata   <= 32'h0;
            r_m1Rdata   <= 32'h0;
        end else begin
            if (w_rAccept[0]) r_rSizeLat0 <= bus.m0_rsize;
            if (w_rAccept[1]) r_rSizeLat1 <= bus.m1_rsize;
            if (w_rLoad) r_rsize <= w_rWinner ? w_rSizeEff1 : w_rSizeEff0;
            r_m0Rdone <= w_rTake && !w_rGrant;
            r_m1Rdone <= w_rTake && w_rGrant;
            if (w_rTake && !w_rGrant) r_m0Rdata <= bus.rdata;
            if (w_rTake && w_rGrant) r_m1Rdata <= bus.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wSizeLat0 <= 2'b00;
            r_wSizeLat1 <= 2'b00;
            r_wDataLat0 <= 32'h0;
            r_wDataLat1 <= 32'h0;
            r_wsize     <= 2'b00;
            r_wdata     <= 32'h0;
            r_m0Wdone   <= 1'b0;
            r_m1Wdone   <= 1'b0;
        end else begin
            if (w_wAccept[0]) begin
                r_wSizeLat0 <= bus.m0_wsize;
                r_wDataLat0 <= bus.m0_wdata;
            end
            if (w_wAccept[1]) begin
                r_wSizeLat1 <= bus.m1_wsize;
                r_wDataLat1 <= bus.m1_wdata;
            end
            if (w_wLoad) begin
                r_wsize <= w_wWinner ? w_wSizeEff1 : w_wSizeEff0;
                r_wdata <= w_wWinner ? w_wDataEff1 : w_wDataEff0;
            end
            r_m0Wdone <= w_wTake && !w_wGrant;
            r_m1Wdone <= w_wTake && w_wGrant;
        end
    end

    assign bus.renable  = w_rIssue;
    assign bus.rsize    = r_rsize;
    assign bus.m0_rdone = r_m0Rdone;
    assign bus.m1_rdone = r_m1Rdone;
    assign bus.m0_rdata = r_m0Rdata;
    assign bus.m1_rdata = r_m1Rdata;
    assign bus.wenable  = w_wIssue;
    assign bus.wsize    = r_wsize;
    assign bus.wdata    = r_wdata;
    assign bus.m0_wdone = r_m0Wdone;
    assign bus.m1_wdone = r_m1Wdone;
endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: a round-robin and a fixed-priority instance share all stimulus;
// directed scenarios use constant expectations, the random run uses a transaction-level model.
module tb_uart_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_renable, m1_renable, m0_wenable, m1_wenable;
    logic [1:0]  m0_rsize, m1_rsize, m0_wsize, m1_wsize;
    logic [31:0] m0_wdata, m1_wdata, rdata;
    logic        rdone, wdone;
    int          vectors = 0;
    int          miscompares = 0;
    int          rPulsesA = 0;
    int          doneCountA = 0;

    uart_arbiter_if ifA();
    uart_arbiter_if ifB();

    assign ifA.m0_renable = m0_renable;  assign ifB.m0_renable = m0_renable;
    assign ifA.m1_renable = m1_renable;  assign ifB.m1_renable = m1_renable;
    assign ifA.m0_rsize   = m0_rsize;    assign ifB.m0_rsize   = m0_rsize;
    assign ifA.m1_rsize   = m1_rsize;    assign ifB.m1_rsize   = m1_rsize;
    assign ifA.m0_wenable = m0_wenable;  assign ifB.m0_wenable = m0_wenable;
    assign ifA.m1_wenable = m1_wenable;  assign ifB.m1_wenable = m1_wenable;
    assign ifA.m0_wsize   = m0_wsize;    assign ifB.m0_wsize   = m0_wsize;
    assign ifA.m1_wsize   = m1_wsize;    assign ifB.m1_wsize   = m1_wsize;
    assign ifA.m0_wdata   = m0_wdata;    assign ifB.m0_wdata   = m0_wdata;
    assign ifA.m1_wdata   = m1_wdata;    assign ifB.m1_wdata   = m1_wdata;
    assign ifA.rdone      = rdone;       assign ifB.rdone      = rdone;
    assign ifA.rdata      = rdata;       assign ifB.rdata      = rdata;
    assign ifA.wdone      = wdone;       assign ifB.wdone      = wdone;

    uart_arbiter #(.FIXED_PRIO(1'b0)) dutA (.clk(clk), .rstn(rstn), .bus(ifA));
    uart_arbiter #(.FIXED_PRIO(1'b1)) dutB (.clk(clk), .rstn(rstn), .bus(ifB));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ifA.renable === 1'b1) rPulsesA++;
        if (ifA.m0_rdone === 1'b1 || ifA.m1_rdone === 1'b1) doneCountA++;
    end

    // Model index k: 0 = read of A, 1 = write of A, 2 = read of B (fixed priority), 3 = write of B.
    bit          mBusy[4];
    bit          mGrant[4];
    bit          mLast[4];
    bit          mPend[4][2];
    logic [1:0]  mSize[4][2];
    logic [31:0] mData[4][2];
    bit          eEn[4];
    logic [1:0]  eSize[4];
    logic [31:0] eWdata[4];
    bit          eDone[4][2];
    logic [31:0] eRdata[4][2];
    logic        obsEn[4];
    logic [1:0]  obsSize[4];
    logic [31:0] obsWdata[4];
    logic        obsDone[4][2];
    logic [31:0] obsRdata[4][2];

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            mBusy[k] = 0; mGrant[k] = 0; mLast[k] = 0; eEn[k] = 0; eSize[k] = 0; eWdata[k] = 0;
            for (int x = 0; x < 2; x++) begin
                mPend[k][x] = 0; mSize[k][x] = 0; mData[k][x] = 0; eDone[k][x] = 0; eRdata[k][x] = 0;
            end
        end
    endtask

    // One clock edge of a channel, stated as transactions: complete, accept new requests, grant.
    task automatic modelStep(input int k, input bit req0, input bit req1, input logic [1:0] s0,
                             input logic [1:0] s1, input logic [31:0] d0, input logic [31:0] d1,
                             input bit done, input logic [31:0] bdata);
        bit completing = 0;
        int w;
        eEn[k] = 0; eDone[k][0] = 0; eDone[k][1] = 0;
        if (mBusy[k] && done) begin
            eDone[k][mGrant[k]] = 1;
            eRdata[k][mGrant[k]] = bdata;
            mPend[k][mGrant[k]] = 0;
            mLast[k] = mGrant[k];
            mBusy[k] = 0;
            completing = 1;
        end
        if (req0 && !mPend[k][0]) begin mPend[k][0] = 1; mSize[k][0] = s0; mData[k][0] = d0; end
        if (req1 && !mPend[k][1]) begin mPend[k][1] = 1; mSize[k][1] = s1; mData[k][1] = d1; end
        if (!mBusy[k] && !completing && (mPend[k][0] || mPend[k][1])) begin
            if (mPend[k][0] && mPend[k][1]) w = (k >= 2) ? 0 : (mLast[k] ? 0 : 1);
            else w = mPend[k][1] ? 1 : 0;
            mBusy[k] = 1; mGrant[k] = w[0]; eEn[k] = 1;
            eSize[k] = mSize[k][w]; eWdata[k] = mData[k][w];
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearInputs();
        m0_renable = 0; m1_renable = 0; m0_wenable = 0; m1_wenable = 0;
        m0_rsize = 0; m1_rsize = 0; m0_wsize = 0; m1_wsize = 0;
        m0_wdata = 0; m1_wdata = 0; rdata = 0; rdone = 0; wdone = 0;
    endtask

    task automatic applyReset();
        rstn = 0;
        clearInputs();
        applyStimulus(2);
        rstn = 1;
        modelReset();
    endtask

    task automatic sampleOutputs();
        obsEn[0] = ifA.renable; obsEn[1] = ifA.wenable; obsEn[2] = ifB.renable; obsEn[3] = ifB.wenable;
        obsSize[0] = ifA.rsize; obsSize[1] = ifA.wsize; obsSize[2] = ifB.rsize; obsSize[3] = ifB.wsize;
        obsWdata[0] = 0; obsWdata[1] = ifA.wdata; obsWdata[2] = 0; obsWdata[3] = ifB.wdata;
        obsDone[0][0] = ifA.m0_rdone; obsDone[0][1] = ifA.m1_rdone;
        obsDone[1][0] = ifA.m0_wdone; obsDone[1][1] = ifA.m1_wdone;
        obsDone[2][0] = ifB.m0_rdone; obsDone[2][1] = ifB.m1_rdone;
        obsDone[3][0] = ifB.m0_wdone; obsDone[3][1] = ifB.m1_wdone;
        obsRdata[0][0] = ifA.m0_rdata; obsRdata[0][1] = ifA.m1_rdata;
        obsRdata[2][0] = ifB.m0_rdata; obsRdata[2][1] = ifB.m1_rdata;
    endtask

    task automatic test_reset();
        rstn = 0;
        clearInputs();
        m0_renable = 1; m1_wenable = 1; m1_wdata = 32'hDEAD_BEEF;
        applyStimulus(2);
        clearInputs();
        vectors++; if (ifA.renable !== 1'b0) begin miscompares++; $display("FAIL reset_renable: got %0h expected 0", ifA.renable); end
        vectors++; if (ifA.wenable !== 1'b0) begin miscompares++; $display("FAIL reset_wenable: got %0h expected 0", ifA.wenable); end
        vectors++; if (ifA.rsize !== 2'b00) begin miscompares++; $display("FAIL reset_rsize: got %0h expected 0", ifA.rsize); end
        vectors++; if (ifA.wsize !== 2'b00) begin miscompares++; $display("FAIL reset_wsize: got %0h expected 0", ifA.wsize); end
        vectors++; if (ifA.wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %0h expected 0", ifA.wdata); end
        vectors++; if ({ifA.m0_rdone, ifA.m1_rdone, ifA.m0_wdone, ifA.m1_wdone} !== 4'b0) begin
            miscompares++; $display("FAIL reset_dones: got %0b expected 0", {ifA.m0_rdone, ifA.m1_rdone, ifA.m0_wdone, ifA.m1_wdone}); end
        vectors++; if ({ifA.m0_rdata, ifA.m1_rdata} !== 64'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %0h expected 0", {ifA.m0_rdata, ifA.m1_rdata}); end
        rstn = 1;
        modelReset();
        applyStimulus(2);
        vectors++; if (ifA.renable !== 1'b0 || ifA.wenable !== 1'b0) begin
            miscompares++; $display("FAIL reset_no_issue: got %0b%0b expected 00", ifA.renable, ifA.wenable); end
    endtask

    task automatic test_single_read();
        applyReset();
        rPulsesA = 0;
        m0_renable = 1; m0_rsize = 2'b11;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.renable !== 1'b1) begin miscompares++; $display("FAIL single_renable: got %0h expected 1", ifA.renable); end
        vectors++; if (ifA.rsize !== 2'b11) begin miscompares++; $display("FAIL single_rsize: got %0h expected 3", ifA.rsize); end
        applyStimulus(1);
        vectors++; if (ifA.renable !== 1'b0) begin miscompares++; $display("FAIL single_renable_wait: got %0h expected 0", ifA.renable); end
        vectors++; if (ifA.rsize !== 2'b11) begin miscompares++; $display("FAIL single_rsize_wait: got %0h expected 3", ifA.rsize); end
        applyStimulus(1);
        rdone = 1; rdata = 32'h1234_5678;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.m0_rdone !== 1'b1) begin miscompares++; $display("FAIL single_m0_rdone: got %0h expected 1", ifA.m0_rdone); end
        vectors++; if (ifA.m0_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL single_m0_rdata: got %0h expected 12345678", ifA.m0_rdata); end
        vectors++; if (ifA.m1_rdone !== 1'b0) begin miscompares++; $display("FAIL single_m1_rdone: got %0h expected 0", ifA.m1_rdone); end
        applyStimulus(1);
        vectors++; if (ifA.m0_rdone !== 1'b0) begin miscompares++; $display("FAIL single_rdone_pulse: got %0h expected 0", ifA.m0_rdone); end
        vectors++; if (ifA.m0_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL single_rdata_hold: got %0h expected 12345678", ifA.m0_rdata); end
        vectors++; if (rPulsesA !== 1) begin miscompares++; $display("FAIL single_pulse_count: got %0d expected 1", rPulsesA); end
    endtask

    task automatic test_arbitration();
        applyReset();
        m0_renable = 1; m0_rsize = 2'b01; m1_renable = 1; m1_rsize = 2'b10;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.renable !== 1'b1 || ifA.rsize !== 2'b10) begin
            miscompares++; $display("FAIL rr_first: got en=%0h size=%0h expected en=1 size=2", ifA.renable, ifA.rsize); end
        vectors++; if (ifB.renable !== 1'b1 || ifB.rsize !== 2'b01) begin
            miscompares++; $display("FAIL prio_first: got en=%0h size=%0h expected en=1 size=1", ifB.renable, ifB.rsize); end
        applyStimulus(1);
        rdone = 1; rdata = 32'hAAAA_0001;
        applyStimulus(1);
        clearInputs();
        vectors++; if ({ifA.m0_rdone, ifA.m1_rdone} !== 2'b01) begin
            miscompares++; $display("FAIL rr_first_done: got %0b expected 01", {ifA.m0_rdone, ifA.m1_rdone}); end
        vectors++; if ({ifB.m0_rdone, ifB.m1_rdone} !== 2'b10) begin
            miscompares++; $display("FAIL prio_first_done: got %0b expected 10", {ifB.m0_rdone, ifB.m1_rdone}); end
        vectors++; if (ifA.renable !== 1'b0) begin miscompares++; $display("FAIL rr_gap: got %0h expected 0", ifA.renable); end
        applyStimulus(1);
        vectors++; if (ifA.renable !== 1'b1 || ifA.rsize !== 2'b01) begin
            miscompares++; $display("FAIL rr_second: got en=%0h size=%0h expected en=1 size=1", ifA.renable, ifA.rsize); end
        vectors++; if (ifB.renable !== 1'b1 || ifB.rsize !== 2'b10) begin
            miscompares++; $display("FAIL prio_second: got en=%0h size=%0h expected en=1 size=2", ifB.renable, ifB.rsize); end
        applyStimulus(1);
        rdone = 1; rdata = 32'hBBBB_0002;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.m0_rdone !== 1'b1 || ifA.m0_rdata !== 32'hBBBB_0002 || ifA.m1_rdata !== 32'hAAAA_0001) begin
            miscompares++; $display("FAIL rr_second_done: got done=%0h d0=%0h d1=%0h expected done=1 d0=bbbb0002 d1=aaaa0001",
                                    ifA.m0_rdone, ifA.m0_rdata, ifA.m1_rdata); end
        vectors++; if (ifB.m1_rdone !== 1'b1 || ifB.m0_rdata !== 32'hAAAA_0001 || ifB.m1_rdata !== 32'hBBBB_0002) begin
            miscompares++; $display("FAIL prio_second_done: got done=%0h d0=%0h d1=%0h expected done=1 d0=aaaa0001 d1=bbbb0002",
                                    ifB.m1_rdone, ifB.m0_rdata, ifB.m1_rdata); end
    endtask

    task automatic test_concurrent();
        applyReset();
        m0_wenable = 1; m0_wsize = 2'b00; m0_wdata = 32'h41; m1_wdata = 32'h5555_AAAA;
        m1_renable = 1; m1_rsize = 2'b11;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.wenable !== 1'b1 || ifA.renable !== 1'b1) begin
            miscompares++; $display("FAIL conc_enables: got w=%0h r=%0h expected 1 1", ifA.wenable, ifA.renable); end
        vectors++; if (ifA.wdata !== 32'h41 || ifA.wsize !== 2'b00 || ifA.rsize !== 2'b11) begin
            miscompares++; $display("FAIL conc_fields: got wdata=%0h wsize=%0h rsize=%0h expected 41 0 3", ifA.wdata, ifA.wsize, ifA.rsize); end
        applyStimulus(1);
        wdone = 1;
        vectors++; if (ifA.wenable !== 1'b0 || ifA.wdata !== 32'h41) begin
            miscompares++; $display("FAIL conc_wait: got wen=%0h wdata=%0h expected 0 41", ifA.wenable, ifA.wdata); end
        applyStimulus(1);
        wdone = 0; rdone = 1; rdata = 32'hCAFE_0001;
        vectors++; if (ifA.m0_wdone !== 1'b1 || ifA.m1_rdone !== 1'b0) begin
            miscompares++; $display("FAIL conc_wdone: got wdone=%0h rdone=%0h expected 1 0", ifA.m0_wdone, ifA.m1_rdone); end
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.m1_rdone !== 1'b1 || ifA.m0_wdone !== 1'b0 || ifA.m1_rdata !== 32'hCAFE_0001) begin
            miscompares++; $display("FAIL conc_rdone: got rdone=%0h wdone=%0h rdata=%0h expected 1 0 cafe0001",
                                    ifA.m1_rdone, ifA.m0_wdone, ifA.m1_rdata); end
    endtask

    task automatic test_back_to_back();
        applyReset();
        rPulsesA = 0;
        m1_renable = 1; m1_rsize = 2'b01;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.renable !== 1'b1 || ifA.rsize !== 2'b01) begin
            miscompares++; $display("FAIL b2b_first: got en=%0h size=%0h expected 1 1", ifA.renable, ifA.rsize); end
        applyStimulus(1);
        m1_renable = 1; m1_rsize = 2'b10;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.renable !== 1'b0 || ifA.rsize !== 2'b01) begin
            miscompares++; $display("FAIL b2b_ignored: got en=%0h size=%0h expected 0 1", ifA.renable, ifA.rsize); end
        rdone = 1; rdata = 32'h11; m1_renable = 1; m1_rsize = 2'b11;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.m1_rdone !== 1'b1 || ifA.renable !== 1'b0) begin
            miscompares++; $display("FAIL b2b_done: got done=%0h en=%0h expected 1 0", ifA.m1_rdone, ifA.renable); end
        applyStimulus(1);
        vectors++; if (ifA.renable !== 1'b1 || ifA.rsize !== 2'b11) begin
            miscompares++; $display("FAIL b2b_reissue: got en=%0h size=%0h expected 1 3", ifA.renable, ifA.rsize); end
        applyStimulus(1);
        rdone = 1; rdata = 32'h22;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.m1_rdone !== 1'b1 || ifA.m1_rdata !== 32'h22) begin
            miscompares++; $display("FAIL b2b_second_done: got done=%0h data=%0h expected 1 22", ifA.m1_rdone, ifA.m1_rdata); end
        applyStimulus(4);
        vectors++; if (rPulsesA !== 2) begin miscompares++; $display("FAIL b2b_pulse_count: got %0d expected 2", rPulsesA); end
    endtask

    task automatic test_reset_in_wait();
        applyReset();
        m1_wenable = 1; m1_wsize = 2'b10; m1_wdata = 32'h77; m0_renable = 1; m0_rsize = 2'b11;
        applyStimulus(1);
        clearInputs();
        applyStimulus(1);
        wdone = 1; rdone = 1; rdata = 32'h99;
        applyStimulus(1);
        clearInputs();
        m0_renable = 1; m0_rsize = 2'b10;
        applyStimulus(1);
        clearInputs();
        vectors++; if (ifA.renable !== 1'b1 || ifA.m0_rdata !== 32'h99 || ifA.wdata !== 32'h77) begin
            miscompares++; $display("FAIL rstwait_setup: got en=%0h rdata=%0h wdata=%0h expected 1 99 77", ifA.renable, ifA.m0_rdata, ifA.wdata); end
        rstn = 0;
        applyStimulus(1);
        rstn = 1; rdone = 1; rdata = 32'hFFFF_FFFF;
        doneCountA = 0;
        modelReset();
        vectors++; if ({ifA.renable, ifA.rsize, ifA.m0_rdata, ifA.wdata, ifA.wenable} !== 68'h0) begin
            miscompares++; $display("FAIL rstwait_outputs: got en=%0h rsize=%0h rdata=%0h wdata=%0h expected all 0",
                                    ifA.renable, ifA.rsize, ifA.m0_rdata, ifA.wdata); end
        applyStimulus(1);
        clearInputs();
        vectors++; if ({ifA.m0_rdone, ifA.m1_rdone, ifA.renable, ifA.m0_rdata} !== 35'h0) begin
            miscompares++; $display("FAIL rstwait_late_done: got done=%0b%0b en=%0h rdata=%0h expected 0",
                                    ifA.m0_rdone, ifA.m1_rdone, ifA.renable, ifA.m0_rdata); end
        applyStimulus(2);
        vectors++; if (doneCountA !== 0) begin miscompares++; $display("FAIL rstwait_done_count: got %0d expected 0", doneCountA); end
    endtask

    task automatic test_random();
        bit rd, wd;
        applyReset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rd = mBusy[0] ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
            wd = mBusy[1] ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
            m0_renable = ($urandom_range(0, 99) < 30); m1_renable = ($urandom_range(0, 99) < 30);
            m0_wenable = ($urandom_range(0, 99) < 30); m1_wenable = ($urandom_range(0, 99) < 30);
            m0_rsize = 2'($urandom); m1_rsize = 2'($urandom); m0_wsize = 2'($urandom); m1_wsize = 2'($urandom);
            m0_wdata = $urandom; m1_wdata = $urandom; rdata = $urandom;
            rdone = rd; wdone = wd;
            for (int d = 0; d < 2; d++) begin
                modelStep(2 * d, m0_renable, m1_renable, m0_rsize, m1_rsize, 32'h0, 32'h0, rd, rdata);
                modelStep(2 * d + 1, m0_wenable, m1_wenable, m0_wsize, m1_wsize, m0_wdata, m1_wdata, wd, 32'h0);
            end
            applyStimulus(1);
            sampleOutputs();
            for (int k = 0; k < 4; k++) begin
                vectors++; if (obsEn[k] !== eEn[k]) begin
                    miscompares++; $display("FAIL rand_enable[%0d] cycle %0d: got %0h expected %0h", k, cyc, obsEn[k], eEn[k]); end
                vectors++; if (obsSize[k] !== eSize[k]) begin
                    miscompares++; $display("FAIL rand_size[%0d] cycle %0d: got %0h expected %0h", k, cyc, obsSize[k], eSize[k]); end
                if (k % 2 == 1) begin
                    vectors++; if (obsWdata[k] !== eWdata[k]) begin
                        miscompares++; $display("FAIL rand_wdata[%0d] cycle %0d: got %0h expected %0h", k, cyc, obsWdata[k], eWdata[k]); end
                end
                for (int x = 0; x < 2; x++) begin
                    vectors++; if (obsDone[k][x] !== eDone[k][x]) begin
                        miscompares++; $display("FAIL rand_done[%0d][%0d] cycle %0d: got %0h expected %0h", k, x, cyc, obsDone[k][x], eDone[k][x]); end
                    if (k % 2 == 0) begin
                        vectors++; if (obsRdata[k][x] !== eRdata[k][x]) begin
                            miscompares++; $display("FAIL rand_rdata[%0d][%0d] cycle %0d: got %0h expected %0h", k, x, cyc, obsRdata[k][x], eRdata[k][x]); end
                    end
                end
            end
        end
        clearInputs();
        applyStimulus(1);
    endtask

    initial begin
        clearInputs();
        rstn = 0;
        applyStimulus(1);
        test_reset();
        test_single_read();
        test_arbitration();
        test_concurrent();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
